// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg
//  Shared types and constants for the operand loader.
//  - ld_state_t      : loader FSM states
//  - DEFAULT_TIMEOUT : default A->B strobe window in clk cycles
//  - tmr_w()         : timer width for a given TIMEOUT (minimum 1 bit)
package operand_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_VALID  = 2'd2
  } ld_state_t;

  localparam int DEFAULT_TIMEOUT = 1000;

  // $clog2(1) is 0, so TIMEOUT=0 still gets a 1-bit timer.
  function automatic int tmr_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/operand_loader_sync_edge.sv
// operand_loader_sync_edge
//  Synchronises the asynchronous load strobe and emits a one-cycle pulse per
//  0->1 transition. Raw edge to load_pulse_o latency is SYNC_STAGES+1 clk.
//  Ports:
//   clk           in  clock
//   rst_n         in  async active-low reset
//   strobe_raw_i  in  asynchronous strobe, active high
//   load_pulse_o  out registered single-cycle pulse
module operand_loader_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_raw_i,
  output logic load_pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_raw_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      // Registered edge detect: a held-high strobe yields one pulse only.
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign load_pulse_o = pulse_q;

endmodule

// File: rtl/operand_loader.sv
// operand_loader
//  Captures two operands from a shared bus, one per load strobe, and offers
//  the pair downstream with a valid/ready handshake. A half-entered pair is
//  discarded after TIMEOUT cycles; strobes arriving while a pair is pending
//  are dropped and flagged.
//  Ports:
//   clk, rst_n   clock / async active-low reset
//   data_in      operand bus, sampled on the cycle load_pulse is seen
//   strobe_raw   asynchronous load strobe
//   clear_i      synchronous clear of overrun_o
//   op_a, op_b   captured operands
//   out_valid    pair valid;  out_ready  consumer accepts
//   timeout_o    1-cycle pulse when a partial pair is discarded
//   overrun_o    sticky dropped-strobe flag
//   pair_count   accepted handshakes, wraps
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              strobe_raw,
  input  logic              clear_i,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              timeout_o,
  output logic              overrun_o,
  output logic [7:0]        pair_count
);

  localparam int TW      = tmr_w(TIMEOUT);
  localparam int TLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TLAST_I);

  logic load_pulse;

  operand_loader_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .strobe_raw_i (strobe_raw),
    .load_pulse_o (load_pulse)
  );

  ld_state_t         state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;

    // Clear first so a same-cycle set below wins.
    if (clear_i) overrun_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_pulse) begin
          op_a_d  = data_in;
          timer_d = '0;
          state_d = S_HAVE_A;
        end
      end
      S_HAVE_A: begin
        // A pulse on the would-be timeout cycle takes priority.
        if (load_pulse) begin
          op_b_d  = data_in;
          state_d = S_VALID;
        end else if (TIMEOUT != 0) begin
          if (timer_q == TLAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else if (timer_q < TMAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_VALID: begin
        if (load_pulse) overrun_d = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign out_valid  = (state_q == S_VALID);
  assign timeout_o  = timeout_q;
  assign overrun_o  = overrun_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       raw, raw2, clear_i, out_ready;
  logic [7:0] op_a, op_b, pair_count;
  logic       out_valid, timeout_o, overrun_o;
  logic [7:0] op_a2, op_b2, pair_count2;
  logic       out_valid2, timeout2, overrun2;

  always #5 clk = ~clk;

  operand_loader #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .strobe_raw(raw),
    .clear_i(clear_i), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .timeout_o(timeout_o), .overrun_o(overrun_o),
    .pair_count(pair_count)
  );

  // No-timeout instance for the held-strobe case.
  operand_loader #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .strobe_raw(raw2),
    .clear_i(1'b0), .op_a(op_a2), .op_b(op_b2), .out_valid(out_valid2),
    .out_ready(1'b0), .timeout_o(timeout2), .overrun_o(overrun2),
    .pair_count(pair_count2)
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;
  int vld_run = 0;
  int max_run = 0;

  // Monitor: every handshake pops one expected {op_a, op_b, count-before}.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL hs_unexpected act=%h_%h_%0d exp=none", op_a, op_b, pair_count);
      end else begin
        e = exp_q.pop_front();
        if ({op_a, op_b, pair_count} !== e) begin
          errors++;
          $display("FAIL hs_pair act=%h_%h_%0d exp=%h_%h_%0d",
                   op_a, op_b, pair_count, e[23:16], e[15:8], e[7:0]);
        end
      end
    end
    if (rst_n && out_valid) vld_run++; else vld_run = 0;
    if (vld_run > max_run) max_run = vld_run;
  end

  initial begin
    #600000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Raw high 2 clk, low 2 clk; returns just after the capturing edge.
  task automatic strobe(input logic [7:0] d, input bit sel);
    data_in = d;
    if (sel) raw2 = 1'b1; else raw = 1'b1;
    tick(); tick();
    raw = 1'b0; raw2 = 1'b0;
    tick(); tick();
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back({a, b, exp_cnt});
    exp_cnt = exp_cnt + 8'd1;
    strobe(a, 1'b0);
    strobe(b, 1'b0);
  endtask

  task automatic accept();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    int tcnt, tidx;
    rst_n = 1'b0; data_in = 8'h00; raw = 1'b0; raw2 = 1'b0;
    clear_i = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {timeout_o, overrun_o}, 0);
    chk("rst_count", pair_count, 0);
    rst_n = 1'b1;
    tick();

    // 1: basic pair, held while not ready
    pair(8'h12, 8'h34);
    chk("t1_valid", out_valid, 1);
    chk("t1_op_a", op_a, 8'h12);
    chk("t1_op_b", op_b, 8'h34);
    tick(); tick();
    chk("t1_hold", {out_valid, op_a, op_b}, {1'b1, 8'h12, 8'h34});
    accept();
    chk("t1_drop", out_valid, 0);
    chk("t1_count", pair_count, 1);

    // 2: timeout 8 clk after the A capture (capture at edge 4, pulse at 12)
    tcnt = 0; tidx = 0;
    data_in = 8'hAA; raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) raw = 1'b0;
      if (timeout_o) begin tcnt++; tidx = k; end
    end
    chk("t2_to_count", tcnt, 1);
    chk("t2_to_cycle", tidx, 12);
    chk("t2_op_a_kept", op_a, 8'hAA);
    pair(8'h01, 8'h02);
    chk("t2_pair", {out_valid, op_a, op_b}, {1'b1, 8'h01, 8'h02});
    accept();

    // 3: held strobe on the no-timeout instance -> single capture
    tcnt = 0;
    data_in = 8'hC3; raw2 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (timeout2) tcnt++;
    end
    raw2 = 1'b0; tick(); tick(); tick();
    chk("t3_no_timeout", tcnt, 0);
    chk("t3_not_valid", out_valid2, 0);
    chk("t3_op_a", op_a2, 8'hC3);
    strobe(8'h3C, 1'b1);
    chk("t3_pair", {out_valid2, op_a2, op_b2}, {1'b1, 8'hC3, 8'h3C});

    // 4: strobe dropped while valid, pulse coincident with out_ready
    pair(8'h55, 8'h66);
    chk("t4_valid", out_valid, 1);
    data_in = 8'h77; raw = 1'b1;
    tick(); tick();
    raw = 1'b0;
    tick();
    out_ready = 1'b1;   // edge 4 sees load_pulse and out_ready together
    tick();
    out_ready = 1'b0;
    chk("t4_done", out_valid, 0);
    chk("t4_overrun", overrun_o, 1);
    chk("t4_ops_kept", {op_a, op_b}, {8'h55, 8'h66});
    chk("t4_count", pair_count, exp_cnt);
    tick();
    chk("t4_overrun_sticky", overrun_o, 1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("t4_cleared", overrun_o, 0);

    // 5: async reset while holding operand A
    strobe(8'h99, 1'b0);
    tick(); tick();
    chk("t5_have_a", op_a, 8'h99);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ops", {op_a, op_b}, 0);
    chk("t5_rst_flags", {out_valid, timeout_o, overrun_o}, 0);
    chk("t5_rst_count", pair_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    tcnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (timeout_o) tcnt++;
    end
    chk("t5_no_timeout", tcnt, 0);

    // 6: 256 back-to-back pairs, count wraps to 0
    out_ready = 1'b1;
    max_run = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      pair(a, ~a);
    end
    tick(); tick();
    out_ready = 1'b0;
    chk("t6_count_wrap", pair_count, 0);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_valid_run", max_run, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
